// File: rtl/pwr_good_seq_if.sv
// Control/status bundle between board logic and the power-good sequencer.
// Master drives requests and the raw comparator; slave returns staged enables and status.
interface pwr_good_seq_if #(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 8
);
    logic                enable;
    logic                vout_ok;
    logic                clear_fault;
    logic [N_STAGES-1:0] load_en;
    logic                pwr_good;
    logic                fault;
    logic [CNT_W-1:0]    fault_cnt;

    modport master (
        output enable, vout_ok, clear_fault,
        input  load_en, pwr_good, fault, fault_cnt
    );

    modport slave (
        input  enable, vout_ok, clear_fault,
        output load_en, pwr_good, fault, fault_cnt
    );
endinterface

// File: rtl/pwr_good_seq.sv
// Debounces the regulator OK comparator, ramps staged load enables, flags brown-out/timeout.
// Latency: VOUT_OK edge reaches filtered ok after 2+DEBOUNCE cycles; all outputs registered.
// Backpressure: none; level-sampled inputs, outputs follow the state on the transition edge.
module pwr_good_seq #(
    parameter int N_STAGES  = 4,
    parameter int DEBOUNCE  = 16,
    parameter int STAGE_DLY = 256,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    pwr_good_seq_if.slave   bus
);
    localparam int TMAX = (TIMEOUT > STAGE_DLY) ? TIMEOUT : STAGE_DLY;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int DW   = $clog2(DEBOUNCE) + 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_WAIT_OK,
        S_RAMP,
        S_ON,
        S_FAULT
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [N_STAGES-1:0] load_en_q;
    logic                pwr_good_q;
    logic                fault_q;
    logic [CNT_W-1:0]    fault_cnt_q;

    logic                sync1;
    logic                ok_s;
    logic                ok_f;
    logic [DW-1:0]       dcnt;
    logic                deb_hit;
    logic                ok_f_nxt;
    logic                active;

    // The FSM reacts to the filtered level on the same edge it changes.
    always_comb begin
        deb_hit  = 1'b0;
        ok_f_nxt = ok_f;
        active   = 1'b0;
        deb_hit  = (ok_s != ok_f) && (dcnt == DW'(DEBOUNCE - 1));
        ok_f_nxt = deb_hit ? ok_s : ok_f;
        active   = (state == S_WAIT_OK) || (state == S_RAMP) || (state == S_ON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            ok_s  <= 1'b0;
            ok_f  <= 1'b0;
            dcnt  <= '0;
        end else begin
            sync1 <= bus.vout_ok;
            ok_s  <= sync1;
            ok_f  <= ok_f_nxt;
            if ((ok_s == ok_f) || deb_hit)
                dcnt <= '0;
            else
                dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_OFF;
            timer       <= '0;
            load_en_q   <= '0;
            pwr_good_q  <= 1'b0;
            fault_q     <= 1'b0;
            fault_cnt_q <= '0;
        end else if (active && !bus.enable) begin
            // Orderly shutdown outranks a coincident brown-out or timeout.
            state      <= S_OFF;
            load_en_q  <= '0;
            pwr_good_q <= 1'b0;
        end else if ((state == S_WAIT_OK && !ok_f_nxt && timer == TW'(TIMEOUT - 1)) ||
                     ((state == S_RAMP || state == S_ON) && !ok_f_nxt)) begin
            state      <= S_FAULT;
            load_en_q  <= '0;
            pwr_good_q <= 1'b0;
            fault_q    <= 1'b1;
            if (fault_cnt_q != {CNT_W{1'b1}})
                fault_cnt_q <= fault_cnt_q + 1'b1;
        end else begin
            case (state)
                S_OFF: begin
                    if (bus.enable) begin
                        state <= S_WAIT_OK;
                        timer <= '0;
                    end
                end
                S_WAIT_OK: begin
                    if (ok_f_nxt) begin
                        state     <= S_RAMP;
                        load_en_q <= N_STAGES'(1);
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RAMP: begin
                    if (timer == TW'(STAGE_DLY - 1)) begin
                        timer <= '0;
                        if (&load_en_q) begin
                            state      <= S_ON;
                            pwr_good_q <= 1'b1;
                        end else begin
                            load_en_q <= (load_en_q << 1) | N_STAGES'(1);
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ON: begin
                    load_en_q  <= '1;
                    pwr_good_q <= 1'b1;
                end
                S_FAULT: begin
                    if (bus.clear_fault && !bus.enable) begin
                        state   <= S_OFF;
                        fault_q <= 1'b0;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

    assign bus.load_en   = load_en_q;
    assign bus.pwr_good  = pwr_good_q;
    assign bus.fault     = fault_q;
    assign bus.fault_cnt = fault_cnt_q;
endmodule

// File: tb/tb_pwr_good_seq.sv
// Bench for pwr_good_seq: directed timing scenarios plus random traffic against a
// phase/elapsed-time reference model.
module tb_pwr_good_seq;
    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int SD  = 8;
    localparam int TO  = 64;
    localparam int CW  = 2;

    localparam int M_OFF   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_RAMP  = 2;
    localparam int M_ON    = 3;
    localparam int M_FAULT = 4;

    logic clk = 1'b0;
    logic reset;

    pwr_good_seq_if #(.N_STAGES(N), .CNT_W(CW)) bus ();

    pwr_good_seq #(
        .N_STAGES (N),
        .DEBOUNCE (DEB),
        .STAGE_DLY(SD),
        .TIMEOUT  (TO),
        .CNT_W    (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    wire [7:0] obs = {bus.load_en, bus.pwr_good, bus.fault, bus.fault_cnt};

    // Reference model: phase + start cycle; outputs derived from elapsed time.
    int m_cyc  = 0;
    int m_mode = M_OFF;
    int m_t0   = 0;
    int m_run  = 0;
    int m_fcnt = 0;
    bit m_ok   = 1'b0;
    bit m_p1   = 1'b0;
    bit m_p2   = 1'b0;
    bit m_samp;

    always @(posedge clk) begin
        m_cyc = m_cyc + 1;
        if (reset) begin
            m_mode = M_OFF;
            m_run  = 0;
            m_fcnt = 0;
            m_ok   = 1'b0;
            m_p1   = 1'b0;
            m_p2   = 1'b0;
        end else begin
            m_samp = m_p2;
            m_p2   = m_p1;
            m_p1   = bus.vout_ok;
            if (m_samp != m_ok) begin
                m_run = m_run + 1;
                if (m_run == DEB) begin
                    m_ok  = !m_ok;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if ((m_mode == M_WAIT || m_mode == M_RAMP || m_mode == M_ON) && !bus.enable) begin
                m_mode = M_OFF;
            end else if ((m_mode == M_WAIT && !m_ok && (m_cyc - m_t0) == TO) ||
                         ((m_mode == M_RAMP || m_mode == M_ON) && !m_ok)) begin
                m_mode = M_FAULT;
                m_fcnt = (m_fcnt < (1 << CW) - 1) ? m_fcnt + 1 : m_fcnt;
            end else if (m_mode == M_OFF && bus.enable) begin
                m_mode = M_WAIT;
                m_t0   = m_cyc;
            end else if (m_mode == M_WAIT && m_ok) begin
                m_mode = M_RAMP;
                m_t0   = m_cyc;
            end else if (m_mode == M_RAMP && (m_cyc - m_t0) == N * SD) begin
                m_mode = M_ON;
            end else if (m_mode == M_FAULT && bus.clear_fault && !bus.enable) begin
                m_mode = M_OFF;
            end
        end
    end

    function automatic logic [7:0] model_exp();
        logic [N-1:0] le;
        le = '0;
        if (m_mode == M_RAMP)
            le = N'((1 << ((m_cyc - m_t0) / SD + 1)) - 1);
        else if (m_mode == M_ON)
            le = '1;
        return {le, (m_mode == M_ON), (m_mode == M_FAULT), CW'(m_fcnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable      = 1'b0;
        bus.vout_ok     = 1'b1;
        bus.clear_fault = 1'b0;
        do_reset();
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_state got %b want %b", obs, 8'h00);
        else n_pass++;
    endtask

    task automatic test_ramp();
        logic [N-1:0] le;
        repeat (8) tick();
        bus.enable = 1'b1;
        tick();
        for (int k = 1; k <= 34; k++) begin
            tick();
            le = (k >= 25) ? 4'hF : (k >= 17) ? 4'h7 : (k >= 9) ? 4'h3 : 4'h1;
            n_checks++;
            if (obs !== {le, (k >= 33), 1'b0, 2'd0})
                $display("FAIL ramp_E+%0d got %b want %b", k, obs, {le, (k >= 33), 1'b0, 2'd0});
            else n_pass++;
        end
    endtask

    task automatic test_brownout();
        logic [7:0] e;
        bus.vout_ok = 1'b0;
        repeat (3) tick();
        bus.vout_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (obs !== 8'hF8) $display("FAIL glitch_ignored got %b want %b", obs, 8'hF8);
            else n_pass++;
        end
        bus.vout_ok = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = (k >= 6) ? 8'h05 : 8'hF8;
            n_checks++;
            if (obs !== e) $display("FAIL brownout_fall+%0d got %b want %b", k, obs, e);
            else n_pass++;
        end
        bus.vout_ok = 1'b1;
    endtask

    task automatic test_clear();
        bus.clear_fault = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs !== 8'h05) $display("FAIL clear_ignored_en got %b want %b", obs, 8'h05);
            else n_pass++;
        end
        bus.enable = 1'b0;
        tick();
        n_checks++;
        if (obs !== 8'h01) $display("FAIL clear_to_off got %b want %b", obs, 8'h01);
        else n_pass++;
        bus.clear_fault = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        bus.vout_ok = 1'b0;
        do_reset();
        bus.enable = 1'b1;
        tick();
        for (int k = 1; k <= 64; k++) begin
            tick();
            e = (k == 64) ? 8'h05 : 8'h00;
            n_checks++;
            if (obs !== e) $display("FAIL timeout_E+%0d got %b want %b", k, obs, e);
            else n_pass++;
        end
        bus.enable      = 1'b0;
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
    endtask

    task automatic test_shutdown();
        bus.vout_ok = 1'b1;
        do_reset();
        repeat (8) tick();
        bus.enable = 1'b1;
        tick();
        repeat (9) tick();
        n_checks++;
        if (obs !== 8'h30) $display("FAIL shutdown_pre got %b want %b", obs, 8'h30);
        else n_pass++;
        bus.enable = 1'b0;
        tick();
        n_checks++;
        if (obs !== 8'h00) $display("FAIL shutdown_midramp got %b want %b", obs, 8'h00);
        else n_pass++;
        bus.enable = 1'b1;
        tick();
        repeat (40) tick();
        n_checks++;
        if (obs !== 8'hF8) $display("FAIL shutdown_on got %b want %b", obs, 8'hF8);
        else n_pass++;
        bus.vout_ok = 1'b0;
        repeat (5) tick();
        bus.enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (obs !== 8'h00) $display("FAIL shutdown_coincident got %b want %b", obs, 8'h00);
            else n_pass++;
        end
        bus.vout_ok = 1'b1;
    endtask

    task automatic test_saturate();
        logic [7:0] e;
        bus.vout_ok = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.enable = 1'b1;
            tick();
            repeat (64) tick();
            e = {6'b000001, 2'((i + 1 > 3) ? 3 : i + 1)};
            n_checks++;
            if (obs !== e) $display("FAIL saturate_%0d got %b want %b", i, obs, e);
            else n_pass++;
            bus.enable      = 1'b0;
            bus.clear_fault = 1'b1;
            tick();
            bus.clear_fault = 1'b0;
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [7:0] e;
        bus.vout_ok = 1'b1;
        repeat (8) tick();
        bus.enable = 1'b1;
        tick();
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_midramp got %b want %b", obs, 8'h00);
        else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e = (k >= 6) ? 8'h10 : 8'h00;
            n_checks++;
            if (obs !== e) $display("FAIL restart_R+%0d got %b want %b", k, obs, e);
            else n_pass++;
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        logic [7:0] e;
        bus.enable      = 1'b0;
        bus.clear_fault = 1'b0;
        bus.vout_ok     = 1'b1;
        do_reset();
        hold = 10;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                bus.vout_ok = ~bus.vout_ok;
                hold = $urandom_range(1, 90);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
            bus.clear_fault = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 699) == 0);
            tick();
            e = model_exp();
            n_checks++;
            if (obs !== e) $display("FAIL random_cyc%0d got %b want %b", c, obs, e);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.vout_ok     = 1'b1;
        bus.clear_fault = 1'b0;
        test_reset();
        test_ramp();
        test_brownout();
        test_clear();
        test_timeout();
        test_shutdown();
        test_saturate();
        test_reset_mid_ramp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
